// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response channel plus the
// decode-facing instruction register outputs and decode feedback.
interface fetch_unit_if #(
  parameter int unsigned ADDRESS_SIZE = 32
);
  logic                    F_mem_req;
  logic [ADDRESS_SIZE-1:0] F_mem_addr;
  logic                    F_mem_ready;
  logic                    F_mem_rvalid;
  logic [ADDRESS_SIZE-1:0] F_mem_rdata;
  logic                    D_stall;
  logic                    D_b;
  logic [ADDRESS_SIZE-1:0] D_bImmediate;
  logic [ADDRESS_SIZE-1:0] F_instruction;
  logic [ADDRESS_SIZE-1:0] F_pc;
  logic                    F_valid;

  modport master (
    output F_mem_req, F_mem_addr, F_instruction, F_pc, F_valid,
    input  F_mem_ready, F_mem_rvalid, F_mem_rdata, D_stall, D_b, D_bImmediate
  );

  modport slave (
    input  F_mem_req, F_mem_addr, F_instruction, F_pc, F_valid,
    output F_mem_ready, F_mem_rvalid, F_mem_rdata, D_stall, D_b, D_bImmediate
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage: issues one request at a time,
// registers the returned word for decode, and squashes responses made stale by a redirect.
module fetch_unit #(
  parameter int unsigned             ADDRESS_SIZE = 32,
  parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam logic [0:0] ST_REQ  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]              state;
  logic [ADDRESS_SIZE-1:0] pc;
  logic [ADDRESS_SIZE-1:0] inflight_pc;
  logic [ADDRESS_SIZE-1:0] instr_q;
  logic [ADDRESS_SIZE-1:0] f_pc_q;
  logic                    valid_q;
  logic                    kill;

  logic                    consume;
  logic                    redirect;
  logic                    mem_req;
  logic                    accept;
  logic                    resp;
  logic                    latch;
  logic [ADDRESS_SIZE-1:0] target;
  logic                    unused_imm_lsb;

  // Request gated by reset so nothing is issued while the block is held.
  always_comb begin
    consume  = valid_q & ~bus.D_stall;
    redirect = consume & bus.D_b;
    mem_req  = ~reset & (state == ST_REQ) & (~valid_q | consume);
    accept   = mem_req & bus.F_mem_ready;
    resp     = (state == ST_WAIT) & bus.F_mem_rvalid;
    latch    = resp & ~kill & ~redirect;
    target   = {bus.D_bImmediate[ADDRESS_SIZE-1:2], 2'b00};
  end

  assign unused_imm_lsb = ^bus.D_bImmediate[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_REQ;
      pc          <= RESET_PC;
      inflight_pc <= '0;
      kill        <= 1'b0;
    end else begin
      if (redirect) begin
        pc <= target;
      end else if (accept) begin
        pc <= pc + ADDRESS_SIZE'(4);
      end

      if (accept) begin
        inflight_pc <= pc;
      end

      case (state)
        ST_REQ:  if (accept) state <= ST_WAIT;
        ST_WAIT: if (resp)   state <= ST_REQ;
        default:             state <= ST_REQ;
      endcase

      // A response arriving clears kill; otherwise a redirect that orphans the
      // outstanding (or just-issued) request marks its response for discard.
      if (resp) begin
        kill <= 1'b0;
      end else if (redirect && (state == ST_WAIT || accept)) begin
        kill <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      f_pc_q  <= '0;
    end else if (latch) begin
      valid_q <= 1'b1;
      instr_q <= bus.F_mem_rdata;
      f_pc_q  <= inflight_pc;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.F_mem_req     = mem_req;
  assign bus.F_mem_addr    = pc;
  assign bus.F_instruction = instr_q;
  assign bus.F_pc          = f_pc_q;
  assign bus.F_valid       = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a simple auto-responding memory plus
// hand-computed expectations for streaming, stalls, redirects, wrap and reset.
module tb_fetch_unit;

  logic clk;
  logic reset;
  int   tests;
  int   errors;
  logic auto_resp;

  fetch_unit_if #(.ADDRESS_SIZE(32)) bus ();

  fetch_unit #(
    .ADDRESS_SIZE(32),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h0050_0093 + a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: capture the handshake just before the edge, then (in auto
  // mode) answer an accepted request with rvalid on the following cycle.
  task automatic cycle();
    logic        acc;
    logic [31:0] a;
    #1;
    acc = bus.F_mem_req & bus.F_mem_ready;
    a   = bus.F_mem_addr;
    @(posedge clk);
    #1;
    if (auto_resp) begin
      bus.F_mem_rvalid = acc;
      bus.F_mem_rdata  = acc ? word(a) : 32'h0;
    end
  endtask

  initial begin
    tests = 0;
    errors = 0;
    auto_resp = 1'b1;
    reset = 1'b1;
    bus.F_mem_ready  = 1'b1;
    bus.F_mem_rvalid = 1'b0;
    bus.F_mem_rdata  = '0;
    bus.D_stall      = 1'b0;
    bus.D_b          = 1'b0;
    bus.D_bImmediate = '0;

    #12;
    check("rst_valid", bus.F_valid, 0);
    check("rst_req",   bus.F_mem_req, 0);
    check("rst_addr",  bus.F_mem_addr, 32'h0);
    check("rst_pc",    bus.F_pc, 32'h0);
    check("rst_instr", bus.F_instruction, 32'h0);

    reset = 1'b0;
    #1;
    check("first_req",  bus.F_mem_req, 1);
    check("first_addr", bus.F_mem_addr, 32'h0);

    cycle();
    check("wait_req",   bus.F_mem_req, 0);
    check("wait_valid", bus.F_valid, 0);
    check("wait_addr",  bus.F_mem_addr, 32'h4);

    cycle();
    check("i0_valid", bus.F_valid, 1);
    check("i0_pc",    bus.F_pc, 32'h0);
    check("i0_instr", bus.F_instruction, 32'h0050_0093);
    check("i0_req",   bus.F_mem_req, 1);
    check("i0_next",  bus.F_mem_addr, 32'h4);

    cycle();
    check("tput_gap", bus.F_valid, 0);
    cycle();
    check("i1_pc", bus.F_pc, 32'h4);
    bus.D_stall = 1'b1;
    #1;
    check("stall_req0", bus.F_mem_req, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_valid", bus.F_valid, 1);
      check("stall_pc",    bus.F_pc, 32'h4);
      check("stall_instr", bus.F_instruction, 32'h0050_0097);
      check("stall_req",   bus.F_mem_req, 0);
    end
    bus.D_stall = 1'b0;
    #1;
    check("unstall_req",  bus.F_mem_req, 1);
    check("unstall_addr", bus.F_mem_addr, 32'h8);
    cycle();
    cycle();
    check("i2_pc", bus.F_pc, 32'h8);
    cycle();
    cycle();
    check("i3_pc",    bus.F_pc, 32'hC);
    check("i3_valid", bus.F_valid, 1);

    // Redirect on the same edge the request for 0x10 is accepted.
    bus.D_b = 1'b1;
    bus.D_bImmediate = 32'h100;
    cycle();
    bus.D_b = 1'b0;
    #1;
    check("rd_valid", bus.F_valid, 0);
    check("rd_req",   bus.F_mem_req, 0);
    check("rd_addr",  bus.F_mem_addr, 32'h100);
    cycle();
    check("rd_drop_valid", bus.F_valid, 0);
    check("rd_drop_req",   bus.F_mem_req, 1);
    check("rd_drop_addr",  bus.F_mem_addr, 32'h100);
    cycle();
    cycle();
    check("rd_tgt_valid", bus.F_valid, 1);
    check("rd_tgt_pc",    bus.F_pc, 32'h100);
    check("rd_tgt_instr", bus.F_instruction, 32'h0050_0193);

    // Redirect with memory not ready: no request issued, nothing to kill.
    bus.D_b = 1'b1;
    bus.D_bImmediate = 32'h203;
    bus.F_mem_ready = 1'b0;
    cycle();
    bus.D_b = 1'b0;
    bus.F_mem_ready = 1'b1;
    #1;
    check("rdnr_valid", bus.F_valid, 0);
    check("rdnr_req",   bus.F_mem_req, 1);
    check("rdnr_addr",  bus.F_mem_addr, 32'h200);
    cycle();
    cycle();
    check("rdnr_tgt_valid", bus.F_valid, 1);
    check("rdnr_tgt_pc",    bus.F_pc, 32'h200);

    // D_b while stalled is not a redirect.
    bus.D_stall = 1'b1;
    bus.D_b = 1'b1;
    bus.D_bImmediate = 32'h300;
    cycle();
    check("bstall_pc",   bus.F_pc, 32'h200);
    check("bstall_addr", bus.F_mem_addr, 32'h204);
    bus.D_stall = 1'b0;
    bus.D_bImmediate = 32'hFFFF_FFFC;
    #1;
    check("bstall_rel_addr", bus.F_mem_addr, 32'h204);

    // Now a real redirect to the top of the address space.
    cycle();
    bus.D_b = 1'b0;
    cycle();
    check("wrap_req",  bus.F_mem_req, 1);
    check("wrap_addr", bus.F_mem_addr, 32'hFFFF_FFFC);
    cycle();
    check("wrap_next", bus.F_mem_addr, 32'h0);
    cycle();
    check("wrap_pc",    bus.F_pc, 32'hFFFF_FFFC);
    check("wrap_instr", bus.F_instruction, 32'h0050_008F);

    // Reset in WAIT, then a stale response right after release.
    auto_resp = 1'b0;
    bus.F_mem_rvalid = 1'b0;
    cycle();
    check("pre_rst_req", bus.F_mem_req, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", bus.F_valid, 0);
    check("mid_rst_req",   bus.F_mem_req, 0);
    check("mid_rst_addr",  bus.F_mem_addr, 32'h0);
    cycle();
    reset = 1'b0;
    bus.F_mem_rvalid = 1'b1;
    bus.F_mem_rdata  = 32'hDEAD_BEEF;
    auto_resp = 1'b1;
    #1;
    check("post_rst_addr", bus.F_mem_addr, 32'h0);
    cycle();
    check("stale_valid", bus.F_valid, 0);
    check("stale_instr", bus.F_instruction, 32'h0);
    cycle();
    check("post_rst_valid", bus.F_valid, 1);
    check("post_rst_pc",    bus.F_pc, 32'h0);
    check("post_rst_instr", bus.F_instruction, 32'h0050_0093);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
